// File: rtl/vscale_md_arbiter.sv
// vscale_md_arbiter: shares one iterative multiply/divide unit between two
// requesters (port 0 = pipeline, port 1 = auxiliary). Arbitration is
// round-robin. Exactly one operation is outstanding at a time, and its result
// is returned to the owning port with a valid/ready handshake.
// Optional feature macro: VSCALE_MD_ARB_KILL_EN adds kill0_i/kill1_i and a
// DRAIN state that absorbs the result of an aborted operation.
module vscale_md_arbiter #(
  parameter int XPR_LEN  = 32,
  parameter int OP_WIDTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0_valid_i,
  output logic                req0_ready_o,
  input  logic [OP_WIDTH-1:0] req0_op_i,
  input  logic [XPR_LEN-1:0]  req0_in_1_i,
  input  logic [XPR_LEN-1:0]  req0_in_2_i,
  input  logic                req1_valid_i,
  output logic                req1_ready_o,
  input  logic [OP_WIDTH-1:0] req1_op_i,
  input  logic [XPR_LEN-1:0]  req1_in_1_i,
  input  logic [XPR_LEN-1:0]  req1_in_2_i,
  output logic                resp0_valid_o,
  input  logic                resp0_ready_i,
  output logic                resp1_valid_o,
  input  logic                resp1_ready_i,
  output logic [XPR_LEN-1:0]  resp_out_o,
`ifdef VSCALE_MD_ARB_KILL_EN
  input  logic                kill0_i,
  input  logic                kill1_i,
`endif
  output logic                md_req_valid_o,
  output logic [OP_WIDTH-1:0] md_req_op_o,
  output logic [XPR_LEN-1:0]  md_req_in_1_o,
  output logic [XPR_LEN-1:0]  md_req_in_2_o,
  input  logic                md_resp_valid_i,
  input  logic [XPR_LEN-1:0]  md_resp_out_i
);

`ifdef VSCALE_MD_ARB_KILL_EN
  typedef enum logic [2:0] {IDLE, ISSUE, BUSY, RESP, DRAIN} state_e;
`else
  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_e;
`endif

  state_e                state_q;
  logic                  owner_q;   // port that owns the outstanding op
  logic                  last_q;    // port served most recently
  logic [OP_WIDTH-1:0]   md_op_q;
  logic [XPR_LEN-1:0]    md_in_1_q;
  logic [XPR_LEN-1:0]    md_in_2_q;
  logic [XPR_LEN-1:0]    result_q;

  logic                  grant;
  logic                  accept;
  logic                  resp_ready_owner;

`ifdef VSCALE_MD_ARB_KILL_EN
  logic                  kill_owner;
  assign kill_owner = owner_q ? kill1_i : kill0_i;
`endif

  // Round-robin grant: a lone requester wins; under contention the port not
  // served last wins.
  always_comb begin
    // NOTE: give every combinational output a default first so no path can
    // leave it unassigned and infer a latch.
    grant = 1'b0;
    if (req0_valid_i && req1_valid_i) grant = ~last_q;
    else                              grant = req1_valid_i;
  end

  // Ready is the only output with a combinational path from the inputs; it is
  // also held low while reset is asserted so every output reads 0 in reset.
`ifdef VSCALE_MD_ARB_KILL_EN
  assign req0_ready_o = rst_n && (state_q == IDLE) && !grant && req0_valid_i && !kill0_i;
  assign req1_ready_o = rst_n && (state_q == IDLE) &&  grant && req1_valid_i && !kill1_i;
`else
  assign req0_ready_o = rst_n && (state_q == IDLE) && !grant && req0_valid_i;
  assign req1_ready_o = rst_n && (state_q == IDLE) &&  grant && req1_valid_i;
`endif

  assign accept           = req0_ready_o | req1_ready_o;
  assign resp_ready_owner = owner_q ? resp1_ready_i : resp0_ready_i;

  // Control FSM plus the registered request and result datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the datapath registers are reset too, because the unit-facing
      // request fields and resp_out must read 0 while in reset.
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      md_op_q   <= '0;
      md_in_1_q <= '0;
      md_in_2_q <= '0;
      result_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every register here samples the
      // pre-edge values regardless of statement order.
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_q   <= ISSUE;
            owner_q   <= grant;
            last_q    <= grant;
            md_op_q   <= grant ? req1_op_i   : req0_op_i;
            md_in_1_q <= grant ? req1_in_1_i : req0_in_1_i;
            md_in_2_q <= grant ? req1_in_2_i : req0_in_2_i;
          end
        end
        ISSUE: begin
`ifdef VSCALE_MD_ARB_KILL_EN
          if (kill_owner) state_q <= DRAIN;
          else
`endif
          state_q <= BUSY;
        end
        BUSY: begin
`ifdef VSCALE_MD_ARB_KILL_EN
          if (kill_owner) state_q <= DRAIN;
          else
`endif
          if (md_resp_valid_i) begin
            result_q <= md_resp_out_i;
            state_q  <= RESP;
          end
        end
        RESP: begin
`ifdef VSCALE_MD_ARB_KILL_EN
          if (kill_owner) state_q <= IDLE;
          else
`endif
          if (resp_ready_owner) state_q <= IDLE;
        end
`ifdef VSCALE_MD_ARB_KILL_EN
        DRAIN: begin
          // The aborted op's result is discarded; result_q keeps its value.
          if (md_resp_valid_i) state_q <= IDLE;
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign md_req_valid_o = (state_q == ISSUE);
  assign md_req_op_o    = md_op_q;
  assign md_req_in_1_o  = md_in_1_q;
  assign md_req_in_2_o  = md_in_2_q;
  assign resp0_valid_o  = (state_q == RESP) && !owner_q;
  assign resp1_valid_o  = (state_q == RESP) &&  owner_q;
  assign resp_out_o     = result_q;

endmodule

// File: tb/tb_vscale_md_arbiter.sv
// Testbench for vscale_md_arbiter: directed vectors, a bench-side model of
// the multiply/divide unit, and a transaction-level reference model checked
// against the DUT outputs on every cycle out of reset.
module tb_vscale_md_arbiter;
  localparam int XL = 32;
  localparam int OW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready_o, req1_ready_o;
  logic [OW-1:0] req0_op = '0, req1_op = '0;
  logic [XL-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic          resp0_valid_o, resp1_valid_o;
  logic          resp0_ready = 1'b0, resp1_ready = 1'b0;
  logic [XL-1:0] resp_out_o;
  logic          kill0 = 1'b0, kill1 = 1'b0;
  logic          md_req_valid_o;
  logic [OW-1:0] md_req_op_o;
  logic [XL-1:0] md_req_in_1_o, md_req_in_2_o;
  logic          md_resp_valid_i;
  logic [XL-1:0] md_resp_out_i;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  vscale_md_arbiter #(.XPR_LEN(XL), .OP_WIDTH(OW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid_i(req0_valid), .req0_ready_o(req0_ready_o), .req0_op_i(req0_op),
    .req0_in_1_i(req0_a), .req0_in_2_i(req0_b),
    .req1_valid_i(req1_valid), .req1_ready_o(req1_ready_o), .req1_op_i(req1_op),
    .req1_in_1_i(req1_a), .req1_in_2_i(req1_b),
    .resp0_valid_o(resp0_valid_o), .resp0_ready_i(resp0_ready),
    .resp1_valid_o(resp1_valid_o), .resp1_ready_i(resp1_ready),
    .resp_out_o(resp_out_o),
`ifdef VSCALE_MD_ARB_KILL_EN
    .kill0_i(kill0), .kill1_i(kill1),
`endif
    .md_req_valid_o(md_req_valid_o), .md_req_op_o(md_req_op_o),
    .md_req_in_1_o(md_req_in_1_o), .md_req_in_2_o(md_req_in_2_o),
    .md_resp_valid_i(md_resp_valid_i), .md_resp_out_i(md_resp_out_i)
  );

  task automatic check(input string name, input logic [XL-1:0] act, input logic [XL-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- multiply/divide unit model ----------------
  function automatic logic [XL-1:0] calc(input logic [OW-1:0] op, input logic [XL-1:0] a,
                                         input logic [XL-1:0] b);
    case (op)
      2'd0:    return a * b;
      2'd1:    return (b == 0) ? '1 : a / b;
      default: return (b == 0) ? a  : a % b;
    endcase
  endfunction

  int            unit_lat = 32;
  logic          unit_active;
  int            unit_start;
  logic [XL-1:0] unit_res;
  logic          unit_strobe;
  logic          stray_v = 1'b0;
  logic [XL-1:0] stray_d = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) unit_active <= 1'b0;
    else if (md_req_valid_o) begin
      unit_active <= 1'b1;
      unit_start  <= cyc;
      unit_res    <= calc(md_req_op_o, md_req_in_1_o, md_req_in_2_o);
    end else if (unit_strobe) unit_active <= 1'b0;
  end

  assign unit_strobe     = unit_active && (cyc == unit_start + unit_lat);
  assign md_resp_valid_i = unit_strobe | stray_v;
  assign md_resp_out_i   = unit_strobe ? unit_res : stray_d;

  // ---------------- reference model ----------------
  // One outstanding op, described by how long ago it was accepted, whether
  // its result has arrived, and whether its owner has aborted it.
  logic          m_busy, m_owner, m_last, m_have, m_dead;
  int            m_age;
  logic [OW-1:0] m_op;
  logic [XL-1:0] m_a, m_b, m_res;
  logic          both_v, exp_rdy0, exp_rdy1, m_kown, m_rdy_own;

  assign both_v    = req0_valid && req1_valid;
  assign exp_rdy0  = !m_busy && req0_valid && !kill0 && (!both_v || m_last != 1'b0);
  assign exp_rdy1  = !m_busy && req1_valid && !kill1 && (!both_v || m_last != 1'b1);
  assign m_kown    = m_owner ? kill1 : kill0;
  assign m_rdy_own = m_owner ? resp1_ready : resp0_ready;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_owner <= 1'b0; m_last <= 1'b1; m_have <= 1'b0; m_dead <= 1'b0;
      m_age <= 0; m_op <= '0; m_a <= '0; m_b <= '0; m_res <= '0;
    end else if (!m_busy) begin
      if (exp_rdy0 || exp_rdy1) begin
        m_busy  <= 1'b1; m_age <= 1; m_have <= 1'b0; m_dead <= 1'b0;
        m_owner <= exp_rdy1; m_last <= exp_rdy1;
        m_op    <= exp_rdy1 ? req1_op : req0_op;
        m_a     <= exp_rdy1 ? req1_a  : req0_a;
        m_b     <= exp_rdy1 ? req1_b  : req0_b;
      end
    end else begin
      m_age <= m_age + 1;
      if (m_dead) begin
        if (md_resp_valid_i) m_busy <= 1'b0;
      end else if (m_have) begin
        if (m_kown || m_rdy_own) m_busy <= 1'b0;
      end else if (m_kown) begin
        m_dead <= 1'b1;
      end else if (m_age >= 2 && md_resp_valid_i) begin
        m_have <= 1'b1;
        m_res  <= md_resp_out_i;
      end
    end
  end

  // Compare process: every cycle out of reset, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("cmp_req0_ready",   req0_ready_o,   exp_rdy0);
      check("cmp_req1_ready",   req1_ready_o,   exp_rdy1);
      check("cmp_md_req_valid", md_req_valid_o, m_busy && m_age == 1);
      check("cmp_md_req_op",    md_req_op_o,    m_op);
      check("cmp_md_req_in_1",  md_req_in_1_o,  m_a);
      check("cmp_md_req_in_2",  md_req_in_2_o,  m_b);
      check("cmp_resp0_valid",  resp0_valid_o,  m_busy && m_have && !m_owner);
      check("cmp_resp1_valid",  resp1_valid_o,  m_busy && m_have &&  m_owner);
      check("cmp_resp_out",     resp_out_o,     m_res);
    end
  end

  // ---------------- transaction monitors ----------------
  int            acc_port[$], acc_cyc[$], hs_port[$], hs_cyc[$];
  logic [XL-1:0] hs_data[$];
  logic          resp0_seen = 1'b0;

  always @(posedge clk) begin
    if (rst_n) begin
      if (req0_ready_o && req0_valid) begin acc_port.push_back(0); acc_cyc.push_back(cyc); end
      if (req1_ready_o && req1_valid) begin acc_port.push_back(1); acc_cyc.push_back(cyc); end
      if (resp0_valid_o && resp0_ready) begin
        hs_port.push_back(0); hs_data.push_back(resp_out_o); hs_cyc.push_back(cyc);
      end
      if (resp1_valid_o && resp1_ready) begin
        hs_port.push_back(1); hs_data.push_back(resp_out_o); hs_cyc.push_back(cyc);
      end
      if (resp0_valid_o) resp0_seen <= 1'b1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_logs();
    acc_port.delete(); acc_cyc.delete(); hs_port.delete(); hs_cyc.delete(); hs_data.delete();
  endtask

  task automatic request(input int p, input logic [OW-1:0] op, input logic [XL-1:0] a,
                         input logic [XL-1:0] b, input int budget, output int acc);
    int n0 = acc_port.size();
    int k  = 0;
    if (p == 0) begin req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1; end
    else        begin req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1; end
    while (acc_port.size() == n0 && k < budget) begin tick(); k++; end
    if (p == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    check($sformatf("accept_port%0d_in_budget", p), acc_port.size() > n0, 1'b1);
    acc = (acc_port.size() > n0) ? acc_cyc[$] : -1;
  endtask

  task automatic wait_resp(input int p, input int budget, output int at);
    int k = 0;
    at = -1;
    while (k < budget) begin
      if ((p == 0) ? resp0_valid_o : resp1_valid_o) begin at = cyc; break; end
      tick(); k++;
    end
    check($sformatf("resp_port%0d_in_budget", p), at >= 0, 1'b1);
  endtask

  task automatic wait_count(input int n, input int budget, input bit handshakes);
    int k = 0;
    while (((handshakes ? hs_port.size() : acc_port.size()) < n) && k < budget) begin
      tick(); k++;
    end
    check(handshakes ? "handshake_count" : "accept_count",
          handshakes ? hs_port.size() : acc_port.size(), n);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req0_ready"},   req0_ready_o,   1'b0);
    check({tag, "_req1_ready"},   req1_ready_o,   1'b0);
    check({tag, "_resp0_valid"},  resp0_valid_o,  1'b0);
    check({tag, "_resp1_valid"},  resp1_valid_o,  1'b0);
    check({tag, "_md_req_valid"}, md_req_valid_o, 1'b0);
    check({tag, "_md_req_op"},    md_req_op_o,    '0);
    check({tag, "_md_req_in_1"},  md_req_in_1_o,  '0);
    check({tag, "_md_req_in_2"},  md_req_in_2_o,  '0);
    check({tag, "_resp_out"},     resp_out_o,     '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed test sequence ----------------
  initial begin
    int a, b, t;
    bit saw;

    // Reset state, with both requesters asking during reset.
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (2) tick();
    check_all_zero("reset");
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // Contention straight out of reset: grants alternate starting with port 0.
    clear_logs();
    unit_lat = 4; resp0_ready = 1'b1; resp1_ready = 1'b1;
    req0_op = 2'd1; req0_a = 100; req0_b = 7;
    req1_op = 2'd0; req1_a = 3;   req1_b = 5;
    req0_valid = 1'b1; req1_valid = 1'b1;
    wait_count(4, 200, 1'b0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_count(4, 200, 1'b1);
    if (acc_port.size() >= 4 && hs_port.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("cont_grant%0d", i), acc_port[i], i % 2);
        check($sformatf("cont_hs_port%0d", i), hs_port[i], i % 2);
        check($sformatf("cont_hs_data%0d", i), hs_data[i], (i % 2) ? 32'd15 : 32'd14);
      end
      check("cont_throughput", acc_cyc[1] - acc_cyc[0], 7);
    end
    tick();

    // Single op: port 0 MUL 7x6 with L=32.
    clear_logs();
    unit_lat = 32;
    req0_op = 2'd0; req0_a = 7; req0_b = 6; req0_valid = 1'b1;
    #2;
    check("single_req0_ready", req0_ready_o, 1'b1);
    tick();
    req0_valid = 1'b0;
    a = (acc_cyc.size() > 0) ? acc_cyc[$] : -1;
    check("single_md_req_valid", md_req_valid_o, 1'b1);
    check("single_md_req_in_1", md_req_in_1_o, 32'd7);
    check("single_md_req_in_2", md_req_in_2_o, 32'd6);
    tick();
    check("single_md_req_pulse", md_req_valid_o, 1'b0);
    wait_resp(0, 100, t);
    check("single_latency", t - a, 34);
    check("single_result", resp_out_o, 32'd42);
    check("single_resp1_idle", resp1_valid_o, 1'b0);
    tick();

    // Backpressure on port 1, with port 0 waiting.
    clear_logs();
    unit_lat = 3; resp1_ready = 1'b0;
    request(1, 2'd0, 3, 5, 50, a);
    wait_resp(1, 50, t);
    req0_op = 2'd1; req0_a = 100; req0_b = 7; req0_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #2;
      check("bp_resp1_valid", resp1_valid_o, 1'b1);
      check("bp_resp_out", resp_out_o, 32'd15);
      check("bp_req0_blocked", req0_ready_o, 1'b0);
      tick();
    end
    resp1_ready = 1'b1;
    tick();
    resp1_ready = 1'b0;
    #2;
    check("bp_resp1_dropped", resp1_valid_o, 1'b0);
    check("bp_req0_ready_after", req0_ready_o, 1'b1);
    tick();
    req0_valid = 1'b0;
    if (acc_cyc.size() > 0 && hs_cyc.size() > 0)
      check("bp_accept_after_hs", acc_cyc[$] - hs_cyc[$], 1);
    wait_resp(0, 50, t);
    check("bp_port0_result", resp_out_o, 32'd14);
    tick();

    // Reset while BUSY, then a stray unit response.
    unit_lat = 20;
    request(0, 2'd0, 9, 9, 50, a);
    repeat (5) tick();
    req0_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_busy");
    tick();
    rst_n = 1'b1; req0_valid = 1'b0;
    stray_d = 32'h1234; stray_v = 1'b1;
    tick();
    stray_v = 1'b0;
    saw = 1'b0;
    repeat (25) begin
      #2;
      if (resp0_valid_o || resp1_valid_o || md_req_valid_o) saw = 1'b1;
      tick();
    end
    check("rst_stray_ignored", saw, 1'b0);
    check("rst_resp_out_clear", resp_out_o, '0);

`ifdef VSCALE_MD_ARB_KILL_EN
    // Kill of port 0 in BUSY: port 1 waits for the drain, then is accepted.
    clear_logs();
    unit_lat = 10; resp0_ready = 1'b1; resp1_ready = 1'b1; resp0_seen = 1'b0;
    request(0, 2'd0, 11, 11, 50, a);
    repeat (3) tick();
    kill0 = 1'b1;
    tick();
    kill0 = 1'b0;
    request(1, 2'd0, 2, 8, 50, b);
    check("kill_busy_drain_accept", b - a, 12);
    check("kill_busy_no_resp0", resp0_seen, 1'b0);
    wait_resp(1, 50, t);
    check("kill_busy_port1_result", resp_out_o, 32'd16);
    tick();

    // Kill on the same edge as the unit response: goes to DRAIN, not RESP.
    resp0_seen = 1'b0;
    unit_lat = 6;
    request(0, 2'd0, 4, 4, 50, a);
    while (cyc < a + 7) tick();
    kill0 = 1'b1;
    tick();
    kill0 = 1'b0;
    repeat (5) tick();
    stray_d = 32'hbeef; stray_v = 1'b1;
    tick();
    stray_v = 1'b0;
    check("kill_same_no_resp0", resp0_seen, 1'b0);
    request(0, 2'd0, 5, 5, 50, b);
    wait_resp(0, 50, t);
    check("kill_same_next_result", resp_out_o, 32'd25);
    tick();
`endif

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vscale_md_arbiter.md
# vscale_md_arbiter

Shares one iterative multiply/divide unit between two requesters (port 0: pipeline, port 1: auxiliary/coprocessor port). It performs round-robin arbitration and registers the winning operation into the unit. It tracks the single outstanding operation and returns the result to its owner with a valid/ready handshake. It sits between the requesters and `vscale_mul_div`, driving that unit's `req_*` inputs and consuming its `resp_*` outputs.

## Interface
- `XPR_LEN`, 32, operand/result width
- `OP_WIDTH`, 2, mul/div op encoding width (matches `MUL_DIV_OP_WIDTH`)

Ports:
- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `req{0,1}_valid`  in  1  requester has operation
- `req{0,1}_ready`  out  1  operation accepted this cycle
- `req{0,1}_op`  in  OP_WIDTH  operation
- `req{0,1}_in_1`, `req{0,1}_in_2`  in  XPR_LEN  operands
- `resp{0,1}_valid`  out  1  result available to owner
- `resp{0,1}_ready`  in  1  owner consumes result
- `resp_out`  out  XPR_LEN  result (shared, qualified by `respN_valid`)
- `kill{0,1}`  in  1  abort requester's outstanding op (only with `VSCALE_MD_ARB_KILL_EN`)
- `md_req_valid`  out  1  start pulse to unit
- `md_req_op`  out  OP_WIDTH  registered op
- `md_req_in_1`, `md_req_in_2`  out  XPR_LEN  registered operands
- `md_resp_valid`  in  1  unit result strobe (one cycle)
- `md_resp_out`  in  XPR_LEN  unit result

## Operation
- States: IDLE, ISSUE, BUSY, RESP, DRAIN (DRAIN exists only with kill enabled).
- IDLE: grant computed from valids. If only one port is valid, it wins. If both are valid, the port not served last wins; `last` resets to 1, so port 0 wins first contention. `reqN_ready = (state==IDLE) & grant==N & reqN_valid`. On accept: capture op/operands into `md_req_*`, set `owner=N`, `last=N`, go to ISSUE.
- ISSUE: `md_req_valid=1` for exactly this cycle; go to BUSY.
- BUSY: wait for `md_resp_valid`. On it: capture `md_resp_out` into the result register and go to RESP.
- RESP: `resp_out`=result register; `resp{owner}_valid=1`, held with result stable until `resp{owner}_ready`. Same-cycle handshake transfers and returns to IDLE. The other port's `resp_valid` stays 0.
- Only one operation is ever outstanding. Both `req_ready` are 0 outside IDLE.
- `md_resp_valid` in IDLE, ISSUE or RESP is spurious and ignored; state and result are unchanged.
- Reset (any state): state=IDLE, `last`=1, owner=0. All outputs are 0: `req*_ready`, `resp*_valid`, `md_req_valid`, `md_req_op`, `md_req_in_*`, `resp_out`. The unit must be reset by the same event. A response arriving after reset is spurious and ignored.

## Timing
- Accept at edge N: `md_req_valid` high in cycle N+1.
- Unit result L cycles after start gives `respN_valid` in cycle N+2+L, which is 1 cycle of arbiter overhead each way.
- Back-to-back: after the RESP handshake at edge M, IDLE is in cycle M+1 and the next accept is at M+1. Throughput is one op per L+3 cycles minimum.
- All outputs are registered or decoded from state only, except `reqN_ready`, which depends combinationally on `req*_valid` (and on `killN` when kill is enabled).

## Configuration
- `VSCALE_MD_ARB_KILL_EN` defined: `kill{0,1}` ports exist.
  - `kill{owner}` in ISSUE or BUSY goes to DRAIN. In ISSUE, `md_req_valid` still pulses.
  - DRAIN waits for `md_resp_valid`, discards the result without updating the result register, and goes to IDLE.
  - `kill{owner}` in RESP drops `resp_valid` and goes to IDLE next cycle.
  - Kill of the non-owner, or kill in IDLE, has no state effect, but `killN` forces `reqN_ready=0` in that cycle.
  - Kill has priority over a same-cycle `md_resp_valid` or `resp_ready`.
- Undefined: no kill ports and no DRAIN state. Every issued op completes to RESP.

## Test plan
- Single op: port 0 MUL 7×6 with unit L=32 → `req0_ready` at accept, `md_req_valid` one cycle later, `resp0_valid` with `resp_out`=42 at accept+34; `resp1_valid` stays 0.
- Contention: both ports valid continuously (port 0 DIV 100/7, port 1 MUL 3×5) → grants alternate 0,1,0,1 starting with 0; results 14 and 15 routed to the correct port.
- Backpressure: `resp1_ready` held 0 for 10 cycles → `resp1_valid` and `resp_out` stable; no new accept; port 0 accepted the cycle after the handshake.
- Reset mid-BUSY: `reset` low for 1 cycle while BUSY → all outputs 0 immediately, state IDLE. A subsequent stray `md_resp_valid` produces no `resp_valid`.
- Kill (KILL_EN): `kill0` in BUSY → no `resp0_valid`. A port 1 request stays not-ready until the unit's response is drained, then is accepted.
- Kill vs. response same cycle (KILL_EN): `kill0` and `md_resp_valid` on the same edge → DRAIN→IDLE path, `resp0_valid` never asserted.
